// File: rtl/opll_bus_pkg.sv
// Shared types and default timing for the OPLL write sequencer.
// All timing values are counted in phiM (clk) cycles.
package opll_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_STB,
        A_WAIT,
        D_STB,
        D_WAIT
    } state_e;

    localparam int OPLL_FIFO_DEPTH = 4;
    localparam int OPLL_WR_PULSE   = 4;
    localparam int OPLL_ADDR_WAIT  = 12;
    localparam int OPLL_DATA_WAIT  = 84;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } opll_cmd_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/opll_write_sequencer_if.sv
// Host request channel plus the OPLL bus pins driven by the sequencer.
// One writer (the sequencer) drives the bus side; the host drives the request side.
interface opll_write_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    import opll_bus_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // Handshake: a request transfers on a clk edge where i_req_valid && o_req_ready.
    // o_req_ready is !full and depends only on the registered level; i_flush wins over a push.
    logic          i_req_valid;
    logic          o_req_ready;
    logic [7:0]    i_req_reg;
    logic [7:0]    i_req_data;
    logic          i_flush;
    logic          o_A0;
    logic          o_CS_n;
    logic          o_WR_n;
    logic [7:0]    o_D;
    logic          o_busy;
    logic [LW-1:0] o_level;
    logic          o_done;
    state_e        o_dbg_state;

    modport master (
        output i_req_valid, i_req_reg, i_req_data, i_flush,
        input  o_req_ready, o_A0, o_CS_n, o_WR_n, o_D, o_busy, o_level, o_done, o_dbg_state
    );

    modport slave (
        input  i_req_valid, i_req_reg, i_req_data, i_flush,
        output o_req_ready, o_A0, o_CS_n, o_WR_n, o_D, o_busy, o_level, o_done, o_dbg_state
    );

endinterface

// File: rtl/opll_cmd_fifo.sv
// Command queue: {reg,data} entries, push/pop/flush, level distinguishes full from empty.
// Head entry is presented combinationally on rdata.
module opll_cmd_fifo
    import opll_bus_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  opll_cmd_t     wdata,
    output opll_cmd_t     rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    opll_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/opll_write_sequencer.sv
// Turns queued {reg,data} writes into OPLL address/data strobes with the chip's wait times.
// Bus pins are registered from the current state, so they trail the state register by one edge.
module opll_write_sequencer
    import opll_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = OPLL_FIFO_DEPTH,
    parameter int WR_PULSE   = OPLL_WR_PULSE,
    parameter int ADDR_WAIT  = OPLL_ADDR_WAIT,
    parameter int DATA_WAIT  = OPLL_DATA_WAIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    opll_write_sequencer_if.slave  bus
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(max3(WR_PULSE, ADDR_WAIT, DATA_WAIT)) + 1;

    state_e        state;
    state_e        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          pop;
    opll_cmd_t     head;
    opll_cmd_t     cmd_q;
    logic [LW-1:0] level;
    logic          fifo_full;
    logic          fifo_empty;
    logic          strobe_n_q;
    logic          a0_q;
    logic [7:0]    d_q;
    logic          done_q;

    opll_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.i_req_valid),
        .pop   (pop),
        .flush (bus.i_flush),
        .wdata ({bus.i_req_reg, bus.i_req_data}),
        .rdata (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Single down-counter, reloaded with (duration-1) on every state entry.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !bus.i_flush) begin
                    pop        = 1'b1;
                    state_next = A_STB;
                    cnt_next   = CW'(WR_PULSE - 1);
                end
            end
            A_STB: begin
                if (cnt == '0) begin
                    state_next = A_WAIT;
                    cnt_next   = CW'(ADDR_WAIT - 1);
                end else cnt_next = cnt - CW'(1);
            end
            A_WAIT: begin
                if (cnt == '0) begin
                    state_next = D_STB;
                    cnt_next   = CW'(WR_PULSE - 1);
                end else cnt_next = cnt - CW'(1);
            end
            D_STB: begin
                if (cnt == '0) begin
                    state_next = D_WAIT;
                    cnt_next   = CW'(DATA_WAIT - 1);
                end else cnt_next = cnt - CW'(1);
            end
            D_WAIT: begin
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - CW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // A0/D only load while in a strobe state, so they hold through the following wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            strobe_n_q <= 1'b1;
            a0_q       <= 1'b0;
            d_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            if (pop) cmd_q <= head;
            strobe_n_q <= !((state == A_STB) || (state == D_STB));
            done_q     <= (state == D_WAIT) && (cnt == '0);
            if (state == A_STB) begin
                a0_q <= 1'b0;
                d_q  <= cmd_q.reg_addr;
            end else if (state == D_STB) begin
                a0_q <= 1'b1;
                d_q  <= cmd_q.data;
            end
        end
    end

    assign bus.o_req_ready = !fifo_full;
    assign bus.o_level     = level;
    assign bus.o_busy      = (state != IDLE) || !fifo_empty;
    assign bus.o_CS_n      = strobe_n_q;
    assign bus.o_WR_n      = strobe_n_q;
    assign bus.o_A0        = a0_q;
    assign bus.o_D         = d_q;
    assign bus.o_done      = done_q;
    assign bus.o_dbg_state = state;

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Bench for opll_write_sequencer: queue/engine reference model, bus-decoding core model,
// scoreboard of expected {reg,data} writes, directed corner cases and random traffic.
`timescale 1ns/1ps
module tb_opll_write_sequencer;
    import opll_bus_pkg::*;

    localparam int DEPTH     = 4;
    localparam int WR_PULSE  = 4;
    localparam int ADDR_WAIT = 12;
    localparam int DATA_WAIT = 84;
    localparam int PERIOD    = 2 * WR_PULSE + ADDR_WAIT + DATA_WAIT + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    opll_write_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    opll_write_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .WR_PULSE   (WR_PULSE),
        .ADDR_WAIT  (ADDR_WAIT),
        .DATA_WAIT  (DATA_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue contents, and how many more cycles the engine stays busy with its current command.
    logic [15:0] m_q[$];
    int          m_timer = 0;
    logic [15:0] exp_q[$];

    task automatic model_edge(input bit v, input logic [15:0] cmd, input bit f, output bit acc);
        bit pop_now;
        pop_now = (m_timer == 0) && (m_q.size() > 0) && !f;
        acc     = v && (m_q.size() < DEPTH) && !f;
        if (m_timer > 0) m_timer--;
        if (f) begin
            m_q.delete();
        end else begin
            if (pop_now) begin
                exp_q.push_back(m_q.pop_front());
                m_timer = PERIOD - 1;
            end
            if (acc) m_q.push_back(cmd);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input logic [7:0] r, input logic [7:0] d, input bit f,
                        output bit acc);
        check("level", 32'(bus.o_level), 32'(m_q.size()));
        check("ready", 32'(bus.o_req_ready), 32'(m_q.size() < DEPTH));
        check("busy", 32'(bus.o_busy), 32'((m_timer > 0) || (m_q.size() > 0)));
        bus.i_req_valid = v;
        bus.i_req_reg   = r;
        bus.i_req_data  = d;
        bus.i_flush     = f;
        model_edge(v, {r, d}, f, acc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, acc);
    endtask

    task automatic push_blocking(input logic [7:0] r, input logic [7:0] d);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 4 * PERIOD) begin
            step(1'b1, r, d, 1'b0, acc);
            guard++;
        end
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_timer > 0 || m_q.size() > 0) && guard < 8 * PERIOD) begin
            idle(1);
            guard++;
        end
        idle(4);
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor / core model / scoreboard ----------------
    logic [7:0] core_regs [256];
    int         cyc        = 0;
    int         done_count = 0;
    int         strobe_starts[$];
    logic       prev_wr_n  = 1'b1;
    logic       prev_a0    = 1'b0;
    logic [7:0] prev_d     = 8'h00;
    int         low_len    = 0;
    int         high_len   = 0;
    bit         seen_addr  = 1'b0;
    bit         had_data   = 1'b0;
    bit         wait_done  = 1'b0;
    logic [7:0] addr_latch = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_wr_n = 1'b1;
            low_len   = 0;
            high_len  = 0;
            seen_addr = 1'b0;
            had_data  = 1'b0;
            wait_done = 1'b0;
        end else begin
            check("cs_eq_wr", 32'(bus.o_CS_n), 32'(bus.o_WR_n));
            if (bus.o_WR_n == 1'b0) begin
                if (prev_wr_n == 1'b1) begin
                    low_len = 1;
                    if (bus.o_A0 == 1'b0) begin
                        if (had_data) check("data_gap_min", 32'(high_len >= DATA_WAIT), 32'd1);
                        strobe_starts.push_back(cyc);
                    end else begin
                        check("addr_gap", 32'(high_len), 32'(ADDR_WAIT));
                    end
                end else begin
                    low_len++;
                    check("a0_stable", 32'(bus.o_A0), 32'(prev_a0));
                    check("d_stable", 32'(bus.o_D), 32'(prev_d));
                end
            end else begin
                if (prev_wr_n == 1'b0) begin
                    check("pulse_width", 32'(low_len), 32'(WR_PULSE));
                    high_len = 0;
                    if (prev_a0 == 1'b0) begin
                        addr_latch = prev_d;
                        seen_addr  = 1'b1;
                    end else begin
                        check("addr_before_data", 32'(seen_addr), 32'd1);
                        seen_addr  = 1'b0;
                        had_data   = 1'b1;
                        wait_done  = 1'b1;
                        core_regs[addr_latch] = prev_d;
                        check("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) check("cmd", {16'h0, addr_latch, prev_d}, 32'(exp_q.pop_front()));
                    end
                end
                high_len++;
            end
            if (bus.o_done) begin
                check("done_expected", 32'(wait_done), 32'd1);
                check("done_timing", 32'(high_len), 32'(DATA_WAIT));
                wait_done = 1'b0;
                done_count++;
            end
            prev_wr_n = bus.o_WR_n;
            prev_a0   = bus.o_A0;
            prev_d    = bus.o_D;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic single_write(input logic [7:0] r, input logic [7:0] d);
        bit acc;
        int dc;
        dc = done_count;
        step(1'b1, r, d, 1'b0, acc);
        check("single_push_acc", 32'(acc), 32'd1);
        check("lat_after_e0", 32'(bus.o_WR_n), 32'd1);
        idle(1);
        check("lat_after_e1", 32'(bus.o_WR_n), 32'd1);
        idle(1);
        check("lat_after_e2", 32'(bus.o_WR_n), 32'd0);
        check("lat_a0", 32'(bus.o_A0), 32'd0);
        check("lat_d", 32'(bus.o_D), 32'(r));
        drain();
        check("single_done_count", 32'(done_count - dc), 32'd1);
        check("single_core_reg", 32'(core_regs[r]), 32'(d));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        int         base;
        int         dc;
        logic [7:0] d30, d20, d10;

        bus.i_req_valid = 1'b0;
        bus.i_req_reg   = 8'h00;
        bus.i_req_data  = 8'h00;
        bus.i_flush     = 1'b0;
        for (int i = 0; i < 256; i++) core_regs[i] = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(bus.o_CS_n), 32'd1);
        check("rst_wr_n", 32'(bus.o_WR_n), 32'd1);
        check("rst_a0", 32'(bus.o_A0), 32'd0);
        check("rst_d", 32'(bus.o_D), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_level", 32'(bus.o_level), 32'd0);
        check("rst_state", 32'(bus.o_dbg_state), 32'(IDLE));
        #2 rst_n = 1'b1;
        @(negedge clk);
        idle(3);

        // Single write with latency and timing checks
        single_write(8'h10, 8'h5A);

        // Primer plus five back-to-back pushes: queue fills, last push stalls, starts spaced PERIOD
        d30 = 8'($urandom_range(0, 255));
        d20 = 8'($urandom_range(0, 255));
        d10 = 8'($urandom_range(0, 255));
        base = strobe_starts.size();
        push_blocking(8'h01, 8'hA5);
        push_blocking(8'h30, 8'h11);
        push_blocking(8'h20, 8'h22);
        push_blocking(8'h30, d30);
        push_blocking(8'h20, d20);
        push_blocking(8'h10, d10);
        drain();
        check("b2b_strobe_count", 32'(strobe_starts.size() - base), 32'd6);
        for (int i = base + 1; i < strobe_starts.size(); i++)
            check("b2b_spacing", 32'(strobe_starts[i] - strobe_starts[i-1]), 32'(PERIOD));
        check("readback_30", 32'(core_regs[8'h30]), 32'(d30));
        check("readback_20", 32'(core_regs[8'h20]), 32'(d20));
        check("readback_10", 32'(core_regs[8'h10]), 32'(d10));

        // Flush during A_WAIT with three queued
        dc = done_count;
        push_blocking(8'h40, 8'h01);
        push_blocking(8'h41, 8'h02);
        push_blocking(8'h42, 8'h03);
        push_blocking(8'h43, 8'h04);
        idle(6);
        check("flush_pre_level", 32'(bus.o_level), 32'd3);
        check("flush_pre_state", 32'(bus.o_dbg_state), 32'(A_WAIT));
        step(1'b0, 8'h00, 8'h00, 1'b1, acc);
        check("flush_level_zero", 32'(bus.o_level), 32'd0);
        drain();
        check("flush_one_done", 32'(done_count - dc), 32'd1);
        check("flush_bus_idle", 32'(bus.o_WR_n), 32'd1);
        check("flush_reg_41_untouched", 32'(core_regs[8'h41]), 32'd0);

        // Reset during D_STB releases the bus asynchronously
        step(1'b1, 8'h55, 8'h66, 1'b0, acc);
        base = 0;
        while (!(bus.o_WR_n == 1'b0 && bus.o_A0 == 1'b1) && base < 2 * PERIOD) begin
            idle(1);
            base++;
        end
        check("reached_d_stb", 32'(bus.o_WR_n == 1'b0 && bus.o_A0 == 1'b1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs_n", 32'(bus.o_CS_n), 32'd1);
        check("arst_wr_n", 32'(bus.o_WR_n), 32'd1);
        check("arst_level", 32'(bus.o_level), 32'd0);
        check("arst_busy", 32'(bus.o_busy), 32'd0);
        check("arst_state", 32'(bus.o_dbg_state), 32'(IDLE));
        m_q.delete();
        exp_q.delete();
        m_timer = 0;
        @(negedge clk);
        idle(2);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("arst_reg_55_untouched", 32'(core_regs[8'h55]), 32'd0);
        single_write(8'h20, 8'h77);

        // Push and flush in the same cycle on an empty queue: nothing runs
        dc = done_count;
        step(1'b1, 8'h60, 8'h99, 1'b1, acc);
        check("pushflush_not_acc", 32'(acc), 32'd0);
        check("pushflush_level", 32'(bus.o_level), 32'd0);
        idle(PERIOD + 5);
        check("pushflush_no_done", 32'(done_count - dc), 32'd0);
        check("pushflush_reg_60", 32'(core_regs[8'h60]), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 39) == 0), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 299) == 0), acc);
        end
        drain();
        check("final_idle_busy", 32'(bus.o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
